// File: rtl/regfile_writeback_if.sv
// Writeback request bus from the ALU / load paths into the register-file write port.
interface regfile_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rt;
  logic        in_regdst;
  logic        in_regwrite;
  logic [31:0] in_data;
  logic [1:0]  in_addr_lo;

  modport master (
    output in_valid, in_opcode, in_rd, in_rt, in_regdst, in_regwrite, in_data, in_addr_lo,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rt, in_regdst, in_regwrite, in_data, in_addr_lo,
    output in_ready
  );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write port: shapes load data, queues writes in a small FIFO,
// issues one write per cycle and flags in-flight destinations for hazard checks.
module regfile_writeback #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_writeback_if.slave  rq,
  input  logic                wr_hold,
  output logic                wr_en,
  output logic [4:0]          wr_addr,
  output logic [31:0]         wr_data,
  input  logic [4:0]          chk_rs,
  input  logic [4:0]          chk_rt,
  output logic                rs_pending,
  output logic                rt_pending,
  output logic [CW-1:0]       count
);

  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   cnt;

  logic [4:0]  dest;
  logic [31:0] shaped;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        ready;
  logic        push;
  logic        pop;

  // Destination select and load-data extraction at enqueue time
  always_comb begin
    dest     = rq.in_regdst ? rq.in_rd : rq.in_rt;
    sel_byte = 8'(rq.in_data >> {rq.in_addr_lo, 3'b000});
    sel_half = rq.in_addr_lo[1] ? rq.in_data[31:16] : rq.in_data[15:0];
    shaped   = rq.in_data;
    case (rq.in_opcode)
      OP_LB:   shaped = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  shaped = {24'd0, sel_byte};
      OP_LH:   shaped = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  shaped = {16'd0, sel_half};
      default: shaped = rq.in_data;
    endcase
  end

  // Readiness looks only at registered occupancy, so a full FIFO never pushes
  always_comb begin
    ready       = (cnt != CW'(DEPTH));
    rq.in_ready = ready;
    push        = rq.in_valid & ready & rq.in_regwrite & (dest != 5'd0);
    wr_en       = (cnt != '0) & ~wr_hold;
    pop         = wr_en;
    wr_addr     = (cnt != '0) ? mem[head].addr : 5'd0;
    wr_data     = (cnt != '0) ? mem[head].data : 32'd0;
    count       = cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      vld  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[tail].addr <= dest;
        mem[tail].data <= shaped;
        vld[tail]      <= 1'b1;
        tail           <= tail + PW'(1);
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Hazard flags over every queued entry, including the one being written
  always_comb begin
    rs_pending = 1'b0;
    rt_pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld[i] && (mem[i].addr == chk_rs)) rs_pending = 1'b1;
      if (vld[i] && (mem[i].addr == chk_rt)) rt_pending = 1'b1;
    end
    rs_pending = rs_pending & (chk_rs != 5'd0);
    rt_pending = rt_pending & (chk_rt != 5'd0);
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a queue-based reference model
// checked every cycle plus hand-computed spot expectations.
module tb_regfile_writeback;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk;
  logic          rst_n;
  logic          wr_hold;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic [4:0]    chk_rs;
  logic [4:0]    chk_rt;
  logic          rs_pending;
  logic          rt_pending;
  logic [CW-1:0] count;

  regfile_writeback_if rq ();

  regfile_writeback #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rq         (rq),
    .wr_hold    (wr_hold),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .chk_rs     (chk_rs),
    .chk_rt     (chk_rt),
    .rs_pending (rs_pending),
    .rt_pending (rt_pending),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: the FIFO as a queue of already-shaped writes
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   plan_pop;
  bit   plan_push;
  ent_t plan_ent;

  function automatic logic [31:0] shape(input logic [5:0] op, input logic [31:0] d,
                                        input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*lo +: 8];
    h = lo[1] ? d[31:16] : d[15:0];
    case (op)
      6'h20:   return 32'($signed(b));
      6'h24:   return {24'd0, b};
      6'h21:   return 32'($signed(h));
      6'h25:   return {16'd0, h};
      default: return d;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [4:0]  dst;
    bit          e_rs;
    bit          e_rt;
    e_addr = (q.size() != 0) ? q[0].a : 5'd0;
    e_data = (q.size() != 0) ? q[0].d : 32'd0;
    e_rs = 0;
    e_rt = 0;
    foreach (q[i]) begin
      if (q[i].a == chk_rs && chk_rs != 0) e_rs = 1;
      if (q[i].a == chk_rt && chk_rt != 0) e_rt = 1;
    end
    chk("model count",      32'(count),       32'(q.size()));
    chk("model in_ready",   32'(rq.in_ready), 32'(q.size() != DEPTH));
    chk("model wr_en",      32'(wr_en),       32'(q.size() != 0 && !wr_hold));
    chk("model wr_addr",    32'(wr_addr),     32'(e_addr));
    chk("model wr_data",    wr_data,          e_data);
    chk("model rs_pending", 32'(rs_pending),  32'(e_rs));
    chk("model rt_pending", 32'(rt_pending),  32'(e_rt));
    dst       = rq.in_regdst ? rq.in_rd : rq.in_rt;
    plan_pop  = rst_n && q.size() != 0 && !wr_hold;
    plan_push = rst_n && rq.in_valid && q.size() != DEPTH && rq.in_regwrite && dst != 0;
    plan_ent.a = dst;
    plan_ent.d = shape(rq.in_opcode, rq.in_data, rq.in_addr_lo);
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (plan_pop)  void'(q.pop_front());
      if (plan_push) q.push_back(plan_ent);
    end
    plan_pop  = 0;
    plan_push = 0;
  end

  always @(negedge rst_n) begin
    q.delete();
    plan_pop  = 0;
    plan_push = 0;
  end

  // Inputs only change one time unit after a rising edge
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rt,
                       input logic regdst, input logic regwrite, input logic [31:0] d,
                       input logic [1:0] lo);
    rq.in_valid    = 1'b1;
    rq.in_opcode   = op;
    rq.in_rd       = rd;
    rq.in_rt       = rt;
    rq.in_regdst   = regdst;
    rq.in_regwrite = regwrite;
    rq.in_data     = d;
    rq.in_addr_lo  = lo;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rt,
                      input logic regdst, input logic regwrite, input logic [31:0] d,
                      input logic [1:0] lo);
    drive(op, rd, rt, regdst, regwrite, d, lo);
    sync();
    rq.in_valid = 1'b0;
  endtask

  logic [5:0]  sh_op   [7] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h21, 6'h24, 6'h23};
  logic [31:0] sh_din  [7] = '{32'h12345680, 32'h12345680, 32'h8001FFFF, 32'h8001FFFF,
                               32'h8001FFFF, 32'h12345680, 32'hCAFEF00D};
  logic [1:0]  sh_lo   [7] = '{2'd0, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2};
  logic [31:0] sh_exp  [7] = '{32'hFFFFFF80, 32'h00000012, 32'hFFFF8001, 32'h00008001,
                               32'hFFFFFFFF, 32'h00000056, 32'hCAFEF00D};
  logic [5:0]  mix_op  [5] = '{6'h00, 6'h20, 6'h24, 6'h21, 6'h25};

  initial begin
    rst_n = 1'b0;
    wr_hold = 1'b0;
    chk_rs = '0;
    chk_rt = '0;
    rq.in_valid = 1'b0;
    rq.in_opcode = '0;
    rq.in_rd = '0;
    rq.in_rt = '0;
    rq.in_regdst = 1'b0;
    rq.in_regwrite = 1'b0;
    rq.in_data = '0;
    rq.in_addr_lo = '0;

    repeat (2) @(negedge clk);
    chk("reset count", 32'(count), 32'd0);
    chk("reset in_ready", 32'(rq.in_ready), 32'd1);
    chk("reset wr_en", 32'(wr_en), 32'd0);
    chk("reset wr_data", wr_data, 32'd0);
    sync();
    rst_n = 1'b1;
    sync();

    // Basic pass-through write, one-cycle latency
    send(6'h00, 5'd5, 5'd0, 1'b1, 1'b1, 32'hDEADBEEF, 2'd0);
    @(negedge clk);
    chk("basic wr_en", 32'(wr_en), 32'd1);
    chk("basic wr_addr", 32'(wr_addr), 32'd5);
    chk("basic wr_data", wr_data, 32'hDEADBEEF);
    chk("basic count1", 32'(count), 32'd1);
    sync();
    @(negedge clk);
    chk("basic count0", 32'(count), 32'd0);
    chk("basic idle wr_en", 32'(wr_en), 32'd0);
    sync();

    // Load-data shaping
    for (int i = 0; i < 7; i++) begin
      send(sh_op[i], 5'd3, 5'd0, 1'b1, 1'b1, sh_din[i], sh_lo[i]);
      @(negedge clk);
      chk("shape wr_data", wr_data, sh_exp[i]);
      sync();
    end

    // Fill under hold, fifth request stalls, then drain in order
    wr_hold = 1'b1;
    for (int i = 1; i <= 4; i++) send(6'h00, 5'd0, 5'(i), 1'b0, 1'b1, 32'(100 + i), 2'd0);
    drive(6'h00, 5'd0, 5'd5, 1'b0, 1'b1, 32'd105, 2'd0);
    @(negedge clk);
    chk("full in_ready", 32'(rq.in_ready), 32'd0);
    chk("full count", 32'(count), 32'd4);
    chk("full hold wr_en", 32'(wr_en), 32'd0);
    sync();
    wr_hold = 1'b0;
    @(negedge clk);
    chk("drain addr1", 32'(wr_addr), 32'd1);
    chk("drain still full", 32'(rq.in_ready), 32'd0);
    sync();
    @(negedge clk);
    chk("drain addr2", 32'(wr_addr), 32'd2);
    chk("drain count3", 32'(count), 32'd3);
    sync();
    rq.in_valid = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      @(negedge clk);
      chk("drain order", 32'(wr_addr), 32'(i));
      chk("drain data", wr_data, 32'(100 + i));
      sync();
    end
    @(negedge clk);
    chk("drain empty", 32'(count), 32'd0);
    sync();

    // Dropped requests: rt=0 destination, and regwrite=0
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(6'h00, 5'd7, 5'd0, 1'b0, 1'b1, 32'h11111111, 2'd0);
      else        drive(6'h00, 5'd7, 5'd0, 1'b1, 1'b0, 32'h22222222, 2'd0);
      @(negedge clk);
      chk("drop handshake", 32'(rq.in_ready), 32'd1);
      sync();
      rq.in_valid = 1'b0;
      @(negedge clk);
      chk("drop count", 32'(count), 32'd0);
      chk("drop wr_en", 32'(wr_en), 32'd0);
      sync();
    end

    // Pending flags with two writes to the same register
    chk_rs = 5'd9;
    chk_rt = 5'd0;
    wr_hold = 1'b1;
    drive(6'h00, 5'd9, 5'd0, 1'b1, 1'b1, 32'h0000AAAA, 2'd0);
    @(negedge clk);
    chk("pend not yet", 32'(rs_pending), 32'd0);
    sync();
    drive(6'h00, 5'd9, 5'd0, 1'b1, 1'b1, 32'h0000BBBB, 2'd0);
    @(negedge clk);
    chk("pend rs", 32'(rs_pending), 32'd1);
    chk("pend rt zero", 32'(rt_pending), 32'd0);
    sync();
    rq.in_valid = 1'b0;
    wr_hold = 1'b0;
    @(negedge clk);
    chk("pend oldest", wr_data, 32'h0000AAAA);
    chk("pend head", 32'(rs_pending), 32'd1);
    sync();
    @(negedge clk);
    chk("pend newest", wr_data, 32'h0000BBBB);
    sync();
    @(negedge clk);
    chk("pend clear", 32'(rs_pending), 32'd0);
    sync();

    // Mixed traffic: wrap-around, simultaneous push/pop, holds
    for (int c = 0; c < 48; c++) begin
      drive(mix_op[c % 5], 5'(c % 8), 5'(c % 5), 1'(c % 2), 1'(c % 11 != 10),
            32'h8070F0A1 ^ (32'(c) * 32'h01030507), 2'(c));
      rq.in_valid = (c % 3 != 2);
      wr_hold = (c % 7 >= 5);
      chk_rs = 5'(c % 8);
      chk_rt = 5'((c + 3) % 5);
      sync();
    end
    rq.in_valid = 1'b0;
    wr_hold = 1'b0;
    repeat (6) sync();

    // Asynchronous reset with entries queued
    wr_hold = 1'b1;
    for (int i = 0; i < 3; i++) send(6'h00, 5'(10 + i), 5'd0, 1'b1, 1'b1, 32'(i), 2'd0);
    @(negedge clk);
    chk("pre-reset count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async count", 32'(count), 32'd0);
    chk("async wr_en", 32'(wr_en), 32'd0);
    chk("async wr_addr", 32'(wr_addr), 32'd0);
    sync();
    rst_n = 1'b1;
    wr_hold = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post-reset wr_en", 32'(wr_en), 32'd0);
      sync();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
